// File: rtl/addsub_accumulator_pkg.sv
// Shared encodings for the add/subtract accumulator: command opcodes,
// control FSM states and the registered flag bundle.
package addsub_accumulator_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      OP_CLR  = 2'b00,
      OP_LOAD = 2'b01,
      OP_ADD  = 2'b10,
      OP_SUB  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_e;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic neg;
   } flags_t;

endpackage

// File: rtl/addsub_accumulator_addsub_unit.sv
// Purely combinational WIDTH-bit two's-complement adder/subtractor.
// Subtraction is a + ~b + 1, so carry is the no-borrow indication.
module addsub_unit
   import addsub_accumulator_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   c;

   // The +1 of the subtract is injected as the carry into bit 0.
   assign c[0] = sub;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign b_eff[gi] = b[gi] ^ sub;
         assign sum[gi]   = a[gi] ^ b_eff[gi] ^ c[gi];
         assign c[gi+1]   = (a[gi] & b_eff[gi]) | (c[gi] & (a[gi] ^ b_eff[gi]));
      end
   endgenerate

   assign carry    = c[WIDTH];
   assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_accumulator.sv
// Command-driven accumulator: accepts CLR/LOAD/ADD/SUB over valid/ready,
// updates the accumulator one cycle later and holds the result until consumed.
module addsub_accumulator
   import addsub_accumulator_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_operand,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_overflow,
   output logic             out_zero,
   output logic             out_neg
);

   state_e           state_q, state_d;
   op_e              op_q;
   logic [WIDTH-1:0] operand_q;
   logic [WIDTH-1:0] acc_q, acc_d;
   flags_t           flags_q, flags_d;

   logic             accept;
   logic             execute;

   logic [WIDTH-1:0] unit_sum;
   logic             unit_carry;
   logic             unit_overflow;

   logic [WIDTH-1:0] res;
   logic             res_carry;
   logic             res_overflow;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = EXEC;
         EXEC:                   state_d = RESP;
         RESP:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // in_ready is gated by reset so upstream never sees a handshake during reset.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      execute   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = ~reset;
            accept   = in_valid;
         end
         EXEC:    execute   = 1'b1;
         RESP:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------ command capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q      <= OP_CLR;
         operand_q <= '0;
      end else if (accept) begin
         op_q      <= op_e'(in_op);
         operand_q <= in_operand;
      end
   end

   // ------------------------------------------------------------ datapath
   addsub_unit #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .a        (acc_q),
      .b        (operand_q),
      .sub      (op_q == OP_SUB),
      .sum      (unit_sum),
      .carry    (unit_carry),
      .overflow (unit_overflow)
   );

   always_comb begin
      res          = '0;
      res_carry    = 1'b0;
      res_overflow = 1'b0;
      case (op_q)
         OP_CLR:  res = '0;
         OP_LOAD: res = operand_q;
         OP_ADD, OP_SUB: begin
            res          = unit_sum;
            res_carry    = unit_carry;
            res_overflow = unit_overflow;
         end
         default: res = '0;
      endcase
   end

   always_comb begin
      acc_d   = acc_q;
      flags_d = flags_q;
      if (execute) begin
         acc_d            = res;
         flags_d.carry    = res_carry;
         flags_d.overflow = res_overflow;
         flags_d.zero     = (res == '0);
         flags_d.neg      = res[WIDTH-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         flags_q <= '0;
      end else begin
         acc_q   <= acc_d;
         flags_q <= flags_d;
      end
   end

   assign out_result   = acc_q;
   assign out_carry    = flags_q.carry;
   assign out_overflow = flags_q.overflow;
   assign out_zero     = flags_q.zero;
   assign out_neg      = flags_q.neg;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Self-checking bench for addsub_accumulator: directed spec vectors, random
// commands against an arithmetic model, backpressure, mid-op reset, streaming.
module tb_addsub_accumulator;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_op;
   logic [W-1:0] in_operand;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         out_carry;
   logic         out_overflow;
   logic         out_zero;
   logic         out_neg;

   int tests_run    = 0;
   int tests_failed = 0;
   int model_acc    = 0;

   addsub_accumulator #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_operand   (in_operand),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_carry    (out_carry),
      .out_overflow (out_overflow),
      .out_zero     (out_zero),
      .out_neg      (out_neg)
   );

   always #5 clk = ~clk;

   function automatic logic [W+3:0] observed();
      return {out_result, out_carry, out_overflow, out_zero, out_neg};
   endfunction

   function automatic int to_signed(input int v);
      return (v >= MOD / 2) ? v - MOD : v;
   endfunction

   // Reference: plain integer arithmetic, returns {result,carry,ovf,zero,neg}.
   function automatic logic [W+3:0] model_step(input logic [1:0] op, input logic [W-1:0] val);
      int a, b, full, r, s;
      logic c, v;
      a = model_acc;
      b = int'(val);
      c = 1'b0;
      v = 1'b0;
      r = 0;
      case (op)
         2'b00: r = 0;
         2'b01: r = b;
         2'b10: begin
            full = a + b;
            r    = full % MOD;
            c    = (full >= MOD);
            s    = to_signed(a) + to_signed(b);
            v    = (s > MOD / 2 - 1) || (s < -(MOD / 2));
         end
         default: begin
            full = a + (MOD - 1 - b) + 1;
            r    = full % MOD;
            c    = (full >= MOD);
            s    = to_signed(a) - to_signed(b);
            v    = (s > MOD / 2 - 1) || (s < -(MOD / 2));
         end
      endcase
      model_acc = r;
      return {r[W-1:0], c, v, (r == 0), (r >= MOD / 2)};
   endfunction

   // Drives one command from IDLE (called at posedge+1) and returns what the
   // DUT presents one cycle after acceptance; lat_ok = not valid in EXEC, valid in RESP.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] val,
                        output logic [W+3:0] obs, output logic lat_ok);
      in_valid   = 1'b1;
      in_op      = op;
      in_operand = val;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      in_op      = 2'($urandom);
      in_operand = W'($urandom);
      lat_ok     = !out_valid && !in_ready;
      @(posedge clk); #1;
      lat_ok     = lat_ok && out_valid;
      obs        = observed();
      if (out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_op      = 2'b00;
      in_operand = '0;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      tests_run++;
      if ({out_valid, observed()} !== 9'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got valid=%b obs=%b expected all 0", out_valid, observed());
      end
      reset = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
      end
      model_acc = 0;
      $display("[TB] reset: in_ready=%b out_valid=%b", in_ready, out_valid);
   endtask

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] val;
      logic [W+3:0] exp;   // {result, carry, overflow, zero, neg}
   } vec_t;

   task automatic test_directed();
      vec_t vecs[$];
      logic [W+3:0] obs;
      logic lat_ok;
      vecs = '{
         '{2'b01, 4'd0,  8'b0000_0010},
         '{2'b10, 4'd4,  8'b0100_0000},
         '{2'b10, 4'd5,  8'b1001_0101},
         '{2'b01, 4'd10, 8'b1010_0001},
         '{2'b11, 4'd5,  8'b0101_1100},
         '{2'b01, 4'd3,  8'b0011_0000},
         '{2'b11, 4'd4,  8'b1111_0001},
         '{2'b01, 4'd7,  8'b0111_0000},
         '{2'b11, 4'd8,  8'b1111_0101},
         '{2'b01, 4'd7,  8'b0111_0000},
         '{2'b11, 4'd7,  8'b0000_1010}
      };
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].val, obs, lat_ok);
         void'(model_step(vecs[i].op, vecs[i].val));
         tests_run++;
         if (obs !== vecs[i].exp || !lat_ok) begin
            tests_failed++;
            $display("FAIL directed_%0d: op=%b val=%0d got %b lat_ok=%b expected %b",
                     i, vecs[i].op, vecs[i].val, obs, lat_ok, vecs[i].exp);
         end else begin
            $display("[TB] directed op=%b val=%0d -> %b", vecs[i].op, vecs[i].val, obs);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0]   op;
      logic [W-1:0] val;
      logic [W+3:0] obs, exp;
      logic lat_ok;
      out_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         op  = 2'($urandom);
         val = W'($urandom);
         issue(op, val, obs, lat_ok);
         exp = model_step(op, val);
         tests_run++;
         if (obs !== exp || !lat_ok) begin
            tests_failed++;
            $display("FAIL random_%0d: op=%b val=%0d got %b lat_ok=%b expected %b",
                     n, op, val, obs, lat_ok, exp);
         end else begin
            $display("[TB] random op=%b val=%0d -> %b", op, val, obs);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W+3:0] obs, exp;
      logic lat_ok;
      out_ready = 1'b0;
      issue(2'b10, 4'd3, obs, lat_ok);
      exp = model_step(2'b10, 4'd3);
      tests_run++;
      if (obs !== exp || !lat_ok) begin
         tests_failed++;
         $display("FAIL bp_result: got %b lat_ok=%b expected %b", obs, lat_ok, exp);
      end
      in_valid   = 1'b1;
      in_op      = 2'b01;
      in_operand = 4'd9;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== exp) begin
            tests_failed++;
            $display("FAIL bp_hold_%0d: got valid=%b in_ready=%b obs=%b expected valid=1 in_ready=0 obs=%b",
                     k, out_valid, in_ready, observed(), exp);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || out_result !== exp[W+3:4]) begin
         tests_failed++;
         $display("FAIL bp_no_second_cmd: got valid=%b result=%0d expected 0/%0d",
                  out_valid, out_result, exp[W+3:4]);
      end
      $display("[TB] backpressure: held result %b", exp);
   endtask

   task automatic test_reset_mid_exec();
      logic [W+3:0] obs;
      logic lat_ok;
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      in_op      = 2'b01;
      in_operand = 4'd6;
      @(posedge clk); #1;
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || observed() !== 8'b0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_exec: got valid=%b obs=%b in_ready=%b expected 0/0/0",
                  out_valid, observed(), in_ready);
      end
      @(posedge clk); #1;
      reset     = 1'b0;
      model_acc = 0;
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid_exec_after: got valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      issue(2'b00, 4'd13, obs, lat_ok);
      void'(model_step(2'b00, 4'd13));
      tests_run++;
      if (obs !== 8'b0000_0010 || !lat_ok) begin
         tests_failed++;
         $display("FAIL reset_then_clr: got %b lat_ok=%b expected 00000010", obs, lat_ok);
      end
      $display("[TB] reset mid-EXEC then CLR -> %b", obs);
   endtask

   task automatic test_back_to_back();
      logic [W+3:0] exp_q[$];
      logic [W+3:0] exp;
      int accepted;
      int results;
      accepted   = 0;
      results    = 0;
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      in_op      = 2'($urandom);
      in_operand = W'($urandom);
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            results++;
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL b2b_spurious_result: got %b expected none", observed());
            end else begin
               exp = exp_q.pop_front();
               if (observed() !== exp) begin
                  tests_failed++;
                  $display("FAIL b2b_result: got %b expected %b", observed(), exp);
               end else begin
                  $display("[TB] b2b result %b", observed());
               end
            end
         end
         if (in_ready) begin
            accepted++;
            exp_q.push_back(model_step(in_op, in_operand));
         end
         @(posedge clk); #1;
         if (in_ready == 1'b0 && dut.state_q != 2'b10 && accepted > 0) begin
            in_op      = 2'($urandom);
            in_operand = W'($urandom);
         end
      end
      in_valid = 1'b0;
      tests_run++;
      if (accepted != 4 || results != 4) begin
         tests_failed++;
         $display("FAIL b2b_throughput: got accepted=%0d results=%0d expected 4/4", accepted, results);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid_exec();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
